// File: rtl/mdu.sv
// Iterative RISC-V M-extension multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, with a fixed latency of WIDTH+2 cycles.
module mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    input  logic             kill,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0]   ALL1_W  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]      CNT_TOP = CW'(WIDTH-1);
    localparam logic [CW-1:0]      CNT_ONE = CW'(1);
    localparam logic [CW-1:0]      CNT_Z   = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] ra_r;
    logic [WIDTH-1:0] rb_r;
    logic [WIDTH-1:0] opd_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             neg_r;
    logic             rsign_r;
    logic             dz_r;
    logic             ovf_r;
    logic             done_r;
    logic [WIDTH-1:0] out_r;

    logic             signed_a_s;
    logic             signed_b_s;
    logic             sa_s;
    logic             sb_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic [2*WIDTH-1:0] prod_raw_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] result_s;

    assign ready = (state_r == IDLE);
    assign done  = done_r;
    assign out   = out_r;

    // Operand signedness and magnitudes, used while in PREP.
    always_comb begin
        signed_a_s = !((op_r == 3'd3) || (op_r == 3'd5) || (op_r == 3'd7));
        signed_b_s = signed_a_s && (op_r != 3'd2);
        sa_s       = signed_a_s && ra_r[WIDTH-1];
        sb_s       = signed_b_s && rb_r[WIDTH-1];
        if (sa_s) begin
            mag_a_s = ~ra_r + ONE_W;
        end else begin
            mag_a_s = ra_r;
        end
        if (sb_s) begin
            mag_b_s = ~rb_r + ONE_W;
        end else begin
            mag_b_s = rb_r;
        end
    end

    // One radix-2 step: hi:lo is the product (mul) or remainder:quotient (div).
    always_comb begin
        if (lo_r[0]) begin
            mul_sum_s = {1'b0, hi_r} + {1'b0, opd_r};
        end else begin
            mul_sum_s = {1'b0, hi_r};
        end
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, opd_r};
    end

    // Sign correction and special-case override applied in FIX.
    always_comb begin
        prod_raw_s = {hi_r, lo_r};
        if (neg_r) begin
            prod_s = ~prod_raw_s + ONE_2W;
            quot_s = ~lo_r + ONE_W;
        end else begin
            prod_s = prod_raw_s;
            quot_s = lo_r;
        end
        if (rsign_r) begin
            rem_s = ~hi_r + ONE_W;
        end else begin
            rem_s = hi_r;
        end
        case (op_r)
            3'd0:    result_s = prod_s[WIDTH-1:0];
            3'd1,
            3'd2,
            3'd3:    result_s = prod_s[2*WIDTH-1:WIDTH];
            3'd4:    result_s = dz_r ? ALL1_W : (ovf_r ? ra_r : quot_s);
            3'd5:    result_s = dz_r ? ALL1_W : quot_s;
            3'd6:    result_s = dz_r ? ra_r : (ovf_r ? ZERO_W : rem_s);
            3'd7:    result_s = dz_r ? ra_r : rem_s;
            default: result_s = out_r;
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_Z;
            op_r    <= 3'd0;
            ra_r    <= ZERO_W;
            rb_r    <= ZERO_W;
            opd_r   <= ZERO_W;
            hi_r    <= ZERO_W;
            lo_r    <= ZERO_W;
            neg_r   <= 1'b0;
            rsign_r <= 1'b0;
            dz_r    <= 1'b0;
            ovf_r   <= 1'b0;
            done_r  <= 1'b0;
            out_r   <= ZERO_W;
        end else begin
            done_r <= 1'b0;
            if (kill && (state_r != IDLE)) begin
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            op_r    <= funct3;
                            ra_r    <= ra;
                            rb_r    <= rb;
                            state_r <= PREP;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    PREP: begin
                        opd_r   <= op_r[2] ? mag_b_s : mag_a_s;
                        lo_r    <= op_r[2] ? mag_a_s : mag_b_s;
                        hi_r    <= ZERO_W;
                        neg_r   <= sa_s ^ sb_s;
                        rsign_r <= sa_s;
                        dz_r    <= op_r[2] && (rb_r == ZERO_W);
                        ovf_r   <= ((op_r == 3'd4) || (op_r == 3'd6)) &&
                                   (ra_r == MIN_W) && (rb_r == ALL1_W);
                        cnt_r   <= CNT_TOP;
                        state_r <= RUN;
                    end
                    RUN: begin
                        if (op_r[2]) begin
                            if (!div_diff_s[WIDTH]) begin
                                hi_r <= div_diff_s[WIDTH-1:0];
                                lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                            end else begin
                                hi_r <= div_shift_s[WIDTH-1:0];
                                lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            hi_r <= mul_sum_s[WIDTH:1];
                            lo_r <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
                        end
                        if (cnt_r == CNT_Z) begin
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    FIX: begin
                        out_r   <= result_s;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed checks of the 32-bit mdu plus a random 8-bit regression against
// an arithmetic reference built from the language's own operators.
module tb_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        kill;
    logic        ready;
    logic        done;
    logic [31:0] out;

    logic        start8;
    logic [2:0]  funct3_8;
    logic [7:0]  ra8;
    logic [7:0]  rb8;
    logic        kill8;
    logic        ready8;
    logic        done8;
    logic [7:0]  out8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .ra(ra), .rb(rb),
        .kill(kill), .ready(ready), .done(done), .out(out)
    );

    mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .funct3(funct3_8), .ra(ra8), .rb(rb8),
        .kill(kill8), .ready(ready8), .done(done8), .out(out8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = f; ra = a; rb = b;
        @(posedge clk); #1;
        start = 1'b0; funct3 = 3'd0; ra = 32'h0; rb = 32'h0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (done !== 1'b1 && lat < 100);
        check({tag, "_lat"}, 32'(lat), 32'd34);
        check(tag, out, exp);
    endtask

    function automatic logic [7:0] ref8(input logic [2:0] f, input logic [7:0] a,
                                        input logic [7:0] b);
        int x, y, p, q, r;
        x = (f == 3'd3 || f == 3'd5 || f == 3'd7) ? int'(a) : int'($signed(a));
        y = (f == 3'd2 || f == 3'd3 || f == 3'd5 || f == 3'd7) ? int'(b) : int'($signed(b));
        if (!f[2]) begin
            p = x * y;
            return (f == 3'd0) ? p[7:0] : p[15:8];
        end
        if (y == 0) return (f[1]) ? a : 8'hFF;
        if (f == 3'd4 && x == -128 && y == -1) return 8'h80;
        if (f == 3'd6 && x == -128 && y == -1) return 8'h00;
        q = x / y;
        r = x % y;
        return f[1] ? r[7:0] : q[7:0];
    endfunction

    task automatic op8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
        int lat;
        logic [7:0] exp;
        exp = ref8(f, a, b);
        @(negedge clk);
        start8 = 1'b1; funct3_8 = f; ra8 = a; rb8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (done8 !== 1'b1 && lat < 100);
        check("w8_lat", 32'(lat), 32'd10);
        if (out8 !== exp)
            $display("  w8 op %0d a=%h b=%h", f, a, b);
        check("w8_res", {24'h0, out8}, {24'h0, exp});
    endtask

    initial begin
        int lat;
        int seen;
        int rdy_bad;
        logic [7:0] a8, b8;
        logic [2:0] f8;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; ra = 32'h0; rb = 32'h0; kill = 1'b0;
        start8 = 1'b0; funct3_8 = 3'd0; ra8 = 8'h0; rb8 = 8'h0; kill8 = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out", out, 32'h0);
        @(negedge clk); rst = 1'b0;

        op32("mul",    3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE);
        op32("mulh",   3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        op32("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        op32("mulhu",  3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
        op32("div",    3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        op32("rem",    3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        op32("divu",   3'd5, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC);
        op32("div0",   3'd4, 32'h00001234, 32'h00000000, 32'hFFFFFFFF);
        op32("divu0",  3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF);
        op32("rem0",   3'd6, 32'h00001234, 32'h00000000, 32'h00001234);
        op32("remu0",  3'd7, 32'h00001234, 32'h00000000, 32'h00001234);
        op32("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        op32("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        op32("mul2",   3'd0, 32'h00001234, 32'h00000010, 32'h00012340);

        // kill ten cycles into an operation
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; ra = 32'd3; rb = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_ready", 32'(ready), 32'd1);
        check("kill_done", 32'(done), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("kill_nodone", 32'(seen), 32'd0);
        check("kill_out", out, 32'h00012340);

        // kill in the FIX cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; ra = 32'd3; rb = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (33) @(posedge clk);
        #1 kill = 1'b1;
        check("fix_busy", 32'(ready), 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        check("fixkill_done", 32'(done), 32'd0);
        check("fixkill_ready", 32'(ready), 32'd1);
        check("fixkill_out", out, 32'h00012340);

        // back-to-back with start held through the done cycle
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; ra = 32'd100; rb = 32'd7;
        @(posedge clk); #1;
        funct3 = 3'd6; ra = 32'd100; rb = 32'd7;
        lat = 0; rdy_bad = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && ready) rdy_bad++;
        end while (done !== 1'b1 && lat < 100);
        check("b2b_lat1", 32'(lat), 32'd34);
        check("b2b_res1", out, 32'd14);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept", 32'(ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && ready) rdy_bad++;
        end while (done !== 1'b1 && lat < 100);
        check("b2b_lat2", 32'(lat), 32'd34);
        check("b2b_res2", out, 32'd2);
        check("b2b_busy", 32'(rdy_bad), 32'd0);

        // asynchronous reset between edges mid-run
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; ra = 32'd7; rb = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_out", out, 32'h0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        #1 rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("arst_nodone", 32'(seen), 32'd0);

        // 8-bit regression
        op8(3'd4, 8'h80, 8'hFF);
        op8(3'd6, 8'h80, 8'hFF);
        for (int i = 0; i < 60; i++) begin
            f8 = 3'($urandom_range(0, 7));
            a8 = 8'($urandom);
            b8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            op8(f8, a8, b8);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
